// File: rtl/data_mem_banked_pkg.sv
// Shared definitions for the banked RV32 data memory: func3 codes, FSM states,
// access sizes and the latched request payload.
package data_mem_banked_pkg;

   // RV32 load/store func3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size in bytes; zero marks an invalid func3
   localparam logic [2:0] DMEM_SIZE_B = 3'd1;
   localparam logic [2:0] DMEM_SIZE_H = 3'd2;
   localparam logic [2:0] DMEM_SIZE_W = 3'd4;

   typedef enum logic [1:0] {
      DMEM_S_IDLE  = 2'd0,
      DMEM_S_SPLIT = 2'd1,
      DMEM_S_RESP  = 2'd2
   } dmem_state_e;

   // Request fields needed to shape the response
   typedef struct packed {
      logic       write;
      logic       uns;
      logic       err;
      logic [1:0] lane;
      logic [2:0] size;
   } dmem_req_t;

   // Decode func3 into an access size, 0 when the code is not legal for the direction
   function automatic logic [2:0] dmem_size(input logic write, input logic [2:0] func3);
      logic [2:0] size;
      size = 3'd0;
      if (write) begin
         case (func3)
            F3_SB:   size = DMEM_SIZE_B;
            F3_SH:   size = DMEM_SIZE_H;
            F3_SW:   size = DMEM_SIZE_W;
            default: size = 3'd0;
         endcase
      end else begin
         case (func3)
            F3_LB, F3_LBU: size = DMEM_SIZE_B;
            F3_LH, F3_LHU: size = DMEM_SIZE_H;
            F3_LW:         size = DMEM_SIZE_W;
            default:       size = 3'd0;
         endcase
      end
      return size;
   endfunction

   // Contiguous byte mask for an access size, lane 0 aligned
   function automatic logic [3:0] dmem_mask(input logic [2:0] size);
      logic [3:0] mask;
      case (size)
         DMEM_SIZE_B: mask = 4'b0001;
         DMEM_SIZE_H: mask = 4'b0011;
         DMEM_SIZE_W: mask = 4'b1111;
         default:     mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data memory: synchronous RAM, registered read-first output.
module dmem_byte_bank #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter string       INIT_FILE   = "",
   parameter int unsigned LANE        = 0
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [7:0]                     wdata,
   output logic [7:0]                     rdata
);

   logic [7:0] mem_q [DEPTH_WORDS];

   // Read-first port: a same-edge write is not visible on rdata until the next read
   always_ff @(posedge clk) begin
      rdata <= mem_q[addr];
      if (we) mem_q[addr] <= wdata;
   end

endmodule

// File: rtl/data_mem_banked.sv
// Banked RV32 data memory: four byte lanes, valid/ready request, one-cycle response.
// Define DMEM_MISALIGN_SPLIT_EN to service word-crossing accesses in two beats;
// otherwise a crossing access returns an error without touching memory.
module data_mem_banked
   import data_mem_banked_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN_BYTES = 33'(4 * DEPTH_WORDS);

   dmem_state_e state_q, state_d, start_state_c;
   logic        ready_q, ready_d;
   dmem_req_t   req_q, req_d;
   logic        accept_c;

   logic [31:0]   off_c;
   logic [AW-1:0] wi_c;
   logic [1:0]    lane_c;
   logic [2:0]    size_c;
   logic          cross_c;
   logic          err_c;

   logic [3:0]    bank_we_c;
   logic [AW-1:0] bank_addr_c;
   logic [31:0]   bank_wdata_c;
   logic [31:0]   bank_rdata_c;

   logic [31:0]   lo_word_c;
   logic [63:0]   pair_c;
   logic [31:0]   shift_c;
   logic [31:0]   load_c;

`ifdef DMEM_MISALIGN_SPLIT_EN
   logic [63:0]   wrot_c;
   logic [7:0]    be_c;
   logic [AW-1:0] wi_q, wi_d;
   logic          cross_q, cross_d;
   logic [3:0]    be_hi_q, be_hi_d;
   logic [31:0]   whi_q, whi_d;
   logic [31:0]   lo_q, lo_d;
`else
   logic [31:0]   wrot_c;
   logic [3:0]    be_c;
`endif

   assign accept_c = req_valid && ready_q;

   // Decode the incoming request: word index, lane, size and error checks
   always_comb begin
      off_c   = req_addr - BASE_ADDR;
      wi_c    = off_c[AW+1:2];
      lane_c  = off_c[1:0];
      size_c  = dmem_size(req_write, req_func3);
      cross_c = (3'({1'b0, lane_c}) + size_c) > 3'd4;
      err_c   = ({1'b0, off_c} >= SPAN_BYTES) || (size_c == 3'd0);
`ifdef DMEM_MISALIGN_SPLIT_EN
      // Last word has no successor; never wrap to word 0
      if (cross_c && (wi_c == {AW{1'b1}})) err_c = 1'b1;
`else
      if (cross_c) err_c = 1'b1;
`endif
   end

   // Rotate store data and byte enables into lane position
   always_comb begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      wrot_c        = {32'h0, req_wdata} << {lane_c, 3'b000};
      be_c          = {4'h0, dmem_mask(size_c)} << lane_c;
      start_state_c = (cross_c && !err_c) ? DMEM_S_SPLIT : DMEM_S_RESP;
`else
      wrot_c        = req_wdata << {lane_c, 3'b000};
      be_c          = dmem_mask(size_c) << lane_c;
      start_state_c = DMEM_S_RESP;
`endif
   end

   // FSM next state, ready and request latch
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      unique case (state_q)
         DMEM_S_IDLE, DMEM_S_RESP: begin
            state_d = DMEM_S_IDLE;
            if (accept_c) state_d = start_state_c;
         end
`ifdef DMEM_MISALIGN_SPLIT_EN
         DMEM_S_SPLIT: state_d = DMEM_S_RESP;
`endif
         default: state_d = DMEM_S_IDLE;
      endcase
      ready_d = (state_d != DMEM_S_SPLIT);
      if (accept_c) begin
         req_d.write = req_write;
         req_d.uns   = !req_write && ((req_func3 == F3_LBU) || (req_func3 == F3_LHU));
         req_d.err   = err_c;
         req_d.lane  = lane_c;
         req_d.size  = size_c;
      end
   end

   // State and ready registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DMEM_S_IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   // Request payload register
   always_ff @(posedge clk) begin
      req_q <= req_d;
   end

`ifdef DMEM_MISALIGN_SPLIT_EN
   // Second-beat context and capture of the first-beat read word
   always_comb begin
      wi_d    = wi_q;
      cross_d = cross_q;
      be_hi_d = be_hi_q;
      whi_d   = whi_q;
      lo_d    = lo_q;
      if (accept_c) begin
         wi_d    = wi_c;
         cross_d = cross_c && !err_c;
         be_hi_d = (req_write && !err_c) ? be_c[7:4] : 4'h0;
         whi_d   = wrot_c[63:32];
      end
      if (state_q == DMEM_S_SPLIT) lo_d = bank_rdata_c;
   end

   // Split-beat registers
   always_ff @(posedge clk) begin
      wi_q    <= wi_d;
      cross_q <= cross_d;
      be_hi_q <= be_hi_d;
      whi_q   <= whi_d;
      lo_q    <= lo_d;
   end
`endif

   // Bank port drive: accept edge uses word wi, split edge uses word wi+1
   always_comb begin
      bank_addr_c  = wi_c;
      bank_wdata_c = wrot_c[31:0];
      bank_we_c    = 4'h0;
      if (accept_c && req_write && !err_c) bank_we_c = be_c[3:0];
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (state_q == DMEM_S_SPLIT) begin
         bank_addr_c  = wi_q + AW'(1);
         bank_wdata_c = whi_q;
         bank_we_c    = be_hi_q;
      end
`endif
   end

   for (genvar l = 0; l < 4; l++) begin : g_lane
      dmem_byte_bank #(
         .DEPTH_WORDS(DEPTH_WORDS),
         .INIT_FILE  (INIT_FILE),
         .LANE       (l)
      ) u_bank (
         .clk  (clk),
         .we   (bank_we_c[l]),
         .addr (bank_addr_c),
         .wdata(bank_wdata_c[8*l +: 8]),
         .rdata(bank_rdata_c[8*l +: 8])
      );
   end

   // Little-endian merge of the two words, right-justify, then extend
   always_comb begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      lo_word_c = cross_q ? lo_q : bank_rdata_c;
`else
      lo_word_c = bank_rdata_c;
`endif
      pair_c  = {bank_rdata_c, lo_word_c};
      shift_c = 32'(pair_c >> {req_q.lane, 3'b000});
      case (req_q.size)
         DMEM_SIZE_B: load_c = req_q.uns ? {24'h0, shift_c[7:0]}  : {{24{shift_c[7]}}, shift_c[7:0]};
         DMEM_SIZE_H: load_c = req_q.uns ? {16'h0, shift_c[15:0]} : {{16{shift_c[15]}}, shift_c[15:0]};
         default:     load_c = shift_c;
      endcase
   end

   assign req_ready = ready_q;
   assign rsp_valid = (state_q == DMEM_S_RESP);
   assign rsp_err   = rsp_valid && req_q.err;
   assign rsp_rdata = (rsp_valid && !req_q.write && !req_q.err) ? load_c : 32'h0;

endmodule
